// File: rtl/fetch_controller_if.sv
// Fetch controller bus: run control, redirect, boot loader port and instruction-memory drive.
// The controller uses the master modport; whatever drives it uses slave.
interface fetch_controller_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
);
    logic              run_en;
    logic              halt_req;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              load_req;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_ack;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_we;
    logic [DATA_W-1:0] imem_wdata;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_valid;
    logic              flush;
    logic [1:0]        state;

    modport master (
        input  run_en, halt_req, stall, branch_taken, branch_target,
        input  load_req, load_valid, load_addr, load_data,
        output load_ack, imem_addr, imem_we, imem_wdata,
        output fetch_pc, fetch_valid, flush, state
    );

    modport slave (
        output run_en, halt_req, stall, branch_taken, branch_target,
        output load_req, load_valid, load_addr, load_data,
        input  load_ack, imem_addr, imem_we, imem_wdata,
        input  fetch_pc, fetch_valid, flush, state
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: IDLE/LOAD/RUN/HALT FSM, PC sequencing with branch redirect and flush.
// Define FETCH_BOOT_LOAD_EN to enable the boot loader write port and the LOAD state.
module fetch_controller #(
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                 clk,
    input logic                 reset,
    fetch_controller_if.master  bus
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StRun  = 2'b10,
        StHalt = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_q, flush_d;
    logic              load_req;

`ifdef FETCH_BOOT_LOAD_EN
    assign load_req = bus.load_req;
`else
    assign load_req = 1'b0;
    logic unused_load;
    assign unused_load = ^{bus.load_req, bus.load_valid, bus.load_addr, bus.load_data};
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_req) begin
                    state_d = StLoad;
                end else if (bus.run_en) begin
                    state_d = StRun;
                    pc_d    = RESET_PC;
                end
            end
            StLoad: begin
                if (!load_req) state_d = StIdle;
            end
            StRun: begin
                // Branch wins over stall; the PC update still applies on the exit cycle.
                if (bus.branch_taken) begin
                    pc_d = bus.branch_target;
                end else if (!bus.stall) begin
                    pc_d = pc_q + ADDR_W'(1);
                end
                if (bus.halt_req || !bus.run_en) begin
                    state_d = StHalt;
                end else begin
                    flush_d = bus.branch_taken;
                end
            end
            StHalt: begin
                if (load_req) begin
                    state_d = StLoad;
                end else if (bus.run_en && !bus.halt_req) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

`ifdef FETCH_BOOT_LOAD_EN
    logic load_active;
    logic load_write;
    assign load_active    = (state_q == StLoad);
    assign load_write     = load_active && bus.load_valid;
    assign bus.imem_we    = load_write;
    assign bus.load_ack   = load_write;
    assign bus.imem_addr  = load_active ? bus.load_addr : pc_q;
    assign bus.imem_wdata = load_active ? bus.load_data : '0;
`else
    assign bus.imem_we    = 1'b0;
    assign bus.load_ack   = 1'b0;
    assign bus.imem_addr  = pc_q;
    assign bus.imem_wdata = '0;
`endif

    assign bus.fetch_pc    = pc_q;
    assign bus.fetch_valid = (state_q == StRun) && !flush_q;
    assign bus.flush       = flush_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a cycle-level reference model and literal spot checks.
module tb_fetch_controller;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
`ifdef FETCH_BOOT_LOAD_EN
    localparam bit BOOT = 1'b1;
`else
    localparam bit BOOT = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_controller #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(12'h000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: 0=IDLE 1=LOAD 2=RUN 3=HALT
    int m_state;
    int m_pc;
    bit m_flush;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0;
            m_pc    = 0;
            m_flush = 1'b0;
        end else begin
            case (m_state)
                0: begin
                    if (BOOT && bus.load_req) m_state = 1;
                    else if (bus.run_en) begin
                        m_state = 2;
                        m_pc    = 0;
                    end
                end
                1: if (!bus.load_req) m_state = 0;
                2: begin
                    bit leave;
                    leave = bus.halt_req || !bus.run_en;
                    if (bus.branch_taken) m_pc = int'(bus.branch_target);
                    else if (!bus.stall) m_pc = (m_pc + 1) % 4096;
                    m_flush = bus.branch_taken && !leave;
                    m_state = leave ? 3 : 2;
                end
                default: begin
                    if (BOOT && bus.load_req) m_state = 1;
                    else if (bus.run_en && !bus.halt_req) m_state = 2;
                end
            endcase
            if (m_state != 2) m_flush = 1'b0;
        end
    end

    always @(negedge clk) begin
        bit in_load;
        bit wr;
        in_load = (m_state == 1);
        wr      = in_load && bus.load_valid;
        chk("state", int'(bus.state), m_state);
        chk("fetch_pc", int'(bus.fetch_pc), m_pc);
        chk("fetch_valid", int'(bus.fetch_valid), int'(m_state == 2 && !m_flush));
        chk("flush", int'(bus.flush), int'(m_flush));
        chk("imem_we", int'(bus.imem_we), int'(wr));
        chk("load_ack", int'(bus.load_ack), int'(wr));
        if (!in_load) begin
            chk("imem_addr", int'(bus.imem_addr), m_pc);
            chk("imem_wdata", int'(bus.imem_wdata), 0);
        end else if (wr) begin
            chk("imem_addr_ld", int'(bus.imem_addr), int'(bus.load_addr));
            chk("imem_wdata_ld", int'(bus.imem_wdata), int'(bus.load_data));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.run_en = 0; bus.halt_req = 0; bus.stall = 0;
        bus.branch_taken = 0; bus.branch_target = '0;
        bus.load_req = 0; bus.load_valid = 0; bus.load_addr = '0; bus.load_data = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_pc", int'(bus.fetch_pc), 0);
        chk("rst_fv", int'(bus.fetch_valid), 0);
        chk("rst_flush", int'(bus.flush), 0);
        chk("rst_we", int'(bus.imem_we), 0);
        chk("rst_ack", int'(bus.load_ack), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Sequential fetch from reset PC
        bus.run_en = 1;
        @(negedge clk); chk("idle_before_run", int'(bus.state), 0);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("seq_addr", int'(bus.imem_addr), i);
            chk("seq_fv", int'(bus.fetch_valid), 1);
            step();
        end

        // Branch overrides stall at PC=5
        bus.branch_taken = 1; bus.branch_target = 12'h00A; bus.stall = 1;
        @(negedge clk); chk("br_pc5", int'(bus.fetch_pc), 5);
        step();
        bus.branch_taken = 0; bus.stall = 0;
        @(negedge clk);
        chk("br_pc10", int'(bus.fetch_pc), 10);
        chk("br_flush", int'(bus.flush), 1);
        chk("br_fv0", int'(bus.fetch_valid), 0);
        step();
        @(negedge clk);
        chk("br_pc11", int'(bus.fetch_pc), 11);
        chk("br_flush_clr", int'(bus.flush), 0);
        step();

        // Back-to-back branches keep flush high
        bus.branch_taken = 1; bus.branch_target = 12'h020;
        step();
        bus.branch_target = 12'h030;
        @(negedge clk);
        chk("b2b_pc20", int'(bus.fetch_pc), 'h20);
        chk("b2b_flush1", int'(bus.flush), 1);
        step();
        bus.branch_taken = 0;
        @(negedge clk);
        chk("b2b_pc30", int'(bus.fetch_pc), 'h30);
        chk("b2b_flush2", int'(bus.flush), 1);
        step();
        @(negedge clk); chk("b2b_flush_end", int'(bus.flush), 0);
        step();

        // PC wrap 4095 -> 0
        bus.branch_taken = 1; bus.branch_target = 12'hFFF;
        step();
        bus.branch_taken = 0;
        @(negedge clk); chk("wrap_fff", int'(bus.fetch_pc), 'hFFF);
        step();
        @(negedge clk); chk("wrap_000", int'(bus.fetch_pc), 0);
        step();

        // Halt at PC=7 keeps the increment, resume at held PC
        bus.branch_taken = 1; bus.branch_target = 12'h007;
        step();
        bus.branch_taken = 0; bus.halt_req = 1;
        @(negedge clk); chk("halt_pc7", int'(bus.fetch_pc), 7);
        step();
        @(negedge clk);
        chk("halt_state", int'(bus.state), 3);
        chk("halt_pc8", int'(bus.fetch_pc), 8);
        chk("halt_flush", int'(bus.flush), 0);
        step();
        bus.halt_req = 0;
        step();
        @(negedge clk);
        chk("resume_state", int'(bus.state), 2);
        chk("resume_addr", int'(bus.imem_addr), 8);
        step();

        // Branch together with halt: redirect applies, flush suppressed
        bus.branch_taken = 1; bus.branch_target = 12'h040; bus.halt_req = 1;
        step();
        bus.branch_taken = 0; bus.halt_req = 0;
        @(negedge clk);
        chk("brhalt_pc", int'(bus.fetch_pc), 'h40);
        chk("brhalt_flush", int'(bus.flush), 0);
        step();

        // load_valid in RUN must not write
        bus.load_valid = 1; bus.load_addr = 12'h003; bus.load_data = 16'h6414;
        @(negedge clk);
        chk("run_ld_we", int'(bus.imem_we), 0);
        chk("run_ld_ack", int'(bus.load_ack), 0);
        step();

        // Async reset from RUN, then loader request from IDLE
        #1 reset = 1'b1;
        #1;
        chk("arst_state", int'(bus.state), 0);
        chk("arst_fv", int'(bus.fetch_valid), 0);
        bus.run_en = 0; bus.load_req = 1;
        @(negedge clk);
        reset = 1'b0;
        step();
        @(negedge clk);
`ifdef FETCH_BOOT_LOAD_EN
        chk("ld_state", int'(bus.state), 1);
        chk("ld_we", int'(bus.imem_we), 1);
        chk("ld_ack", int'(bus.load_ack), 1);
        chk("ld_addr", int'(bus.imem_addr), 3);
        chk("ld_wdata", int'(bus.imem_wdata), 'h6414);
`else
        chk("noboot_state", int'(bus.state), 0);
        chk("noboot_we", int'(bus.imem_we), 0);
        chk("noboot_ack", int'(bus.load_ack), 0);
`endif
        step();
        bus.load_addr = 12'h004; bus.load_data = 16'h1234; bus.run_en = 1; bus.stall = 1;
        #2 reset = 1'b1;
        #1;
        chk("midrst_we", int'(bus.imem_we), 0);
        chk("midrst_state", int'(bus.state), 0);
        bus.load_req = 0; bus.load_valid = 0; bus.stall = 0;
        @(negedge clk);
        reset = 1'b0;
        step();
        @(negedge clk); chk("rerun_addr", int'(bus.imem_addr), 0);
        step();
        bus.run_en = 0;
        step();
        @(negedge clk); chk("runen_halt", int'(bus.state), 3);
        step();

        // Loader entry from HALT and exit to IDLE
        bus.load_req = 1;
        step();
        bus.load_req = 0;
        step();
        @(negedge clk);
`ifdef FETCH_BOOT_LOAD_EN
        chk("ld_exit_idle", int'(bus.state), 0);
`else
        chk("noboot_halt", int'(bus.state), 3);
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
